// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants for the pipeline control unit.
//   - stall bus width and the five stall patterns (deeper stage freezes more)
//   - control FSM state encoding
//   - default exception vector and zero word
package pipe_ctrl_pkg;

  localparam int STALL_BUS_W = 6;

  // Bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
  localparam logic [STALL_BUS_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_BUS_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_BUS_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_BUS_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_BUS_W-1:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;
  localparam logic [31:0] ZERO_WORD          = 32'h0000_0000;

  typedef enum logic {
    CTRL_IDLE     = 1'b0,
    CTRL_EXC_HOLD = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_stall_wdog.sv
// stall_wdog: consecutive-stall watchdog.
//   Ports:
//     clk           in  : core clock, rising edge
//     rst           in  : asynchronous active-high reset
//     stall_active  in  : stall bus is non-zero this cycle
//     flush         in  : pipeline flush this cycle
//     stall_timeout out : sticky flag, set the edge after the count hits LIMIT
//   Parameters: LIMIT (1..65535), W (counter width).
module stall_wdog #(
  parameter int LIMIT = 255,
  parameter int W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_active,
  input  logic flush,
  output logic stall_timeout
);

  localparam logic [W-1:0] LIMIT_W   = W'(LIMIT);
  localparam logic [W-1:0] COUNT_MAX = '1;

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count         <= '0;
      stall_timeout <= 1'b0;
    end else begin
      // The flag looks at the count held during this cycle, so it rises one
      // edge after the count reaches the limit and never falls until reset.
      if (count == LIMIT_W)
        stall_timeout <= 1'b1;
      if (!stall_active || flush)
        count <= '0;
      else if (count != COUNT_MAX)
        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the five-stage core.
//   Merges stall requests into the 6-bit stall bus (deepest request wins),
//   sequences exception/ERET flushes with a one-cycle hold that masks a stale
//   exc_valid, and drives the redirect PC. A watchdog flags a hung pipeline.
//   Ports:
//     clk, rst (async, active-high)
//     stallreq_if/id/ex/mem in : per-stage stall requests
//     exc_valid, exc_is_eret in: MEM-stage exception / ERET
//     cp0_epc [31:0]         in : EPC (already forwarded)
//     stall [5:0]            out: combinational stall bus
//     flush                  out: combinational flush
//     new_pc [31:0]          out: redirect target, valid with flush
//     stall_timeout          out: sticky watchdog flag
//   Optional macro PIPE_CTRL_PERF_EN adds perf_stall_cycles and
//   perf_flush_count (32-bit wrap-around event counters).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int          WDOG_LIMIT = 255,
  parameter int          WDOG_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallreq_if,
  input  logic                   stallreq_id,
  input  logic                   stallreq_ex,
  input  logic                   stallreq_mem,
  input  logic                   exc_valid,
  input  logic                   exc_is_eret,
  input  logic [31:0]            cp0_epc,
  output logic [STALL_BUS_W-1:0] stall,
  output logic                   flush,
  output logic [31:0]            new_pc,
  output logic                   stall_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]            perf_stall_cycles,
  output logic [31:0]            perf_flush_count
`endif
);

  ctrl_state_t            state;
  logic [STALL_BUS_W-1:0] merged;
  logic                   exc_take;

  always_comb begin
    merged = STALL_NONE;
    if (stallreq_mem)
      merged = STALL_MEM;
    else if (stallreq_ex)
      merged = STALL_EX;
    else if (stallreq_id)
      merged = STALL_ID;
    else if (stallreq_if)
      merged = STALL_IF;
  end

  // rst gates the combinational outputs directly so they read as reset values
  // the moment rst rises, not just after the state register clears.
  assign exc_take = !rst && (state == CTRL_IDLE) && exc_valid;

  always_comb begin
    stall  = (rst || exc_take) ? STALL_NONE : merged;
    flush  = exc_take;
    new_pc = ZERO_WORD;
    if (exc_take)
      new_pc = exc_is_eret ? cp0_epc : EXC_VECTOR;
  end

  // EXC_HOLD always lasts one cycle; exc_valid seen there is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CTRL_IDLE;
    end else begin
      case (state)
        CTRL_IDLE:     state <= exc_valid ? CTRL_EXC_HOLD : CTRL_IDLE;
        CTRL_EXC_HOLD: state <= CTRL_IDLE;
        default:       state <= CTRL_IDLE;
      endcase
    end
  end

  stall_wdog #(
    .LIMIT (WDOG_LIMIT),
    .W     (WDOG_W)
  ) u_wdog (
    .clk           (clk),
    .rst           (rst),
    .stall_active  (stall != STALL_NONE),
    .flush         (flush),
    .stall_timeout (stall_timeout)
  );

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (stall != STALL_NONE)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush)
        perf_flush_count <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl (WDOG_LIMIT=4).
//   Table of stall-merge vectors, hand-written exception/ERET/masking,
//   watchdog and async-reset sequences, then randomized traffic against a
//   behavioural model. Build with PIPE_CTRL_PERF_EN to also check counters.
module tb_pipe_ctrl;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rq_if = 0, rq_id = 0, rq_ex = 0, rq_mem = 0;
  logic        exc_valid = 0, exc_is_eret = 0;
  logic [31:0] cp0_epc = '0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

  pipe_ctrl #(.WDOG_LIMIT(LIMIT)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (rq_if),
    .stallreq_id   (rq_id),
    .stallreq_ex   (rq_ex),
    .stallreq_mem  (rq_mem),
    .exc_valid     (exc_valid),
    .exc_is_eret   (exc_is_eret),
    .cp0_epc       (cp0_epc),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_timeout (stall_timeout)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: "an exception was taken last cycle" masks this one;
  // watchdog = length of the current run of stalled cycles.
  bit          m_mask;
  int          m_run;
  bit          m_to;
  int          m_stall_cyc;
  int          m_flush_cnt;
  logic [5:0]  e_stall;
  logic        e_flush;
  logic [31:0] e_pc;

  typedef struct {
    logic       r_if, r_id, r_ex, r_mem;
    logic [5:0] exp_stall;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mask = 0; m_run = 0; m_to = 0; m_stall_cyc = 0; m_flush_cnt = 0;
  endtask

  // One clock cycle: drive inputs just after the edge, compare at the
  // falling edge, then advance the model across the following edge.
  task automatic apply(input logic a_if, input logic a_id, input logic a_ex,
                       input logic a_mem, input logic ev, input logic eret,
                       input logic [31:0] epc);
    int depth;
    @(posedge clk); #1;
    rq_if = a_if; rq_id = a_id; rq_ex = a_ex; rq_mem = a_mem;
    exc_valid = ev; exc_is_eret = eret; cp0_epc = epc;
    @(negedge clk);
    e_flush = ev && !m_mask;
    depth = a_mem ? 5 : a_ex ? 4 : a_id ? 3 : a_if ? 2 : 0;
    e_stall = e_flush ? 6'd0 : 6'((1 << depth) - 1);
    e_pc = e_flush ? (eret ? epc : 32'h20) : 32'h0;
    chk("stall", {26'd0, stall}, {26'd0, e_stall});
    chk("flush", {31'd0, flush}, {31'd0, e_flush});
    chk("new_pc", new_pc, e_pc);
    chk("timeout", {31'd0, stall_timeout}, {31'd0, m_to});
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall", perf_stall_cycles, m_stall_cyc);
    chk("perf_flush", perf_flush_count, m_flush_cnt);
`endif
    if (m_run == LIMIT) m_to = 1;
    if (e_stall == 0 || e_flush) m_run = 0;
    else if (m_run < 65535) m_run++;
    if (e_stall != 0) m_stall_cyc++;
    if (e_flush) m_flush_cnt++;
    m_mask = e_flush;
  endtask

  // Raise rst between edges with an exception and all stalls pending.
  task automatic async_reset();
    @(posedge clk); #1;
    rq_if = 1; rq_id = 1; rq_ex = 1; rq_mem = 1; exc_valid = 1; exc_is_eret = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_stall", {26'd0, stall}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_new_pc", new_pc, 32'd0);
    chk("rst_timeout", {31'd0, stall_timeout}, 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    chk("rst_perf_stall", perf_stall_cycles, 32'd0);
    chk("rst_perf_flush", perf_flush_count, 32'd0);
`endif
    @(posedge clk); #2;
    rq_if = 0; rq_id = 0; rq_ex = 0; rq_mem = 0; exc_valid = 0;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit act=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int nflush;
    vecs[0] = '{0, 0, 0, 0, 6'b000000};
    vecs[1] = '{0, 1, 0, 0, 6'b000111};
    vecs[2] = '{1, 0, 0, 0, 6'b000011};
    vecs[3] = '{0, 1, 1, 0, 6'b001111};
    vecs[4] = '{1, 1, 1, 1, 6'b011111};
    vecs[5] = '{0, 0, 0, 1, 6'b011111};
    vecs[6] = '{1, 0, 1, 0, 6'b001111};
    vecs[7] = '{1, 1, 0, 0, 6'b000111};

    model_reset();
    #1;
    chk("reset_stall", {26'd0, stall}, 32'd0);
    chk("reset_flush", {31'd0, flush}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Stall merge table, separated by idle cycles to keep the watchdog quiet.
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].r_if, vecs[i].r_id, vecs[i].r_ex, vecs[i].r_mem, 0, 0, 0);
      chk($sformatf("table%0d", i), {26'd0, stall}, {26'd0, vecs[i].exp_stall});
      apply(0, 0, 0, 0, 0, 0, 0);
    end

    // Exception: flush to vector this cycle, nothing next cycle.
    apply(0, 1, 0, 0, 1, 0, 32'hdead_beef);
    chk("exc_flush", {31'd0, flush}, 32'd1);
    chk("exc_pc", new_pc, 32'h20);
    chk("exc_stall", {26'd0, stall}, 32'd0);
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("exc_next_flush", {31'd0, flush}, 32'd0);

    // ERET redirects to EPC.
    apply(0, 0, 0, 0, 1, 1, 32'h0000_1234);
    chk("eret_flush", {31'd0, flush}, 32'd1);
    chk("eret_pc", new_pc, 32'h1234);
    apply(0, 0, 0, 0, 0, 0, 0);

    // Two cycles of exc_valid with a memory stall: one flush only.
    nflush = 0;
    apply(0, 0, 0, 1, 1, 0, 0);
    nflush += int'(flush);
    apply(0, 0, 0, 1, 1, 0, 0);
    nflush += int'(flush);
    chk("mask_stall", {26'd0, stall}, 32'h1f);
    apply(0, 0, 0, 0, 0, 0, 0);
    nflush += int'(flush);
    chk("mask_one_pulse", nflush, 1);

    // Watchdog: EX stall held 6 cycles, timeout visible from the 6th cycle.
    async_reset();
    for (int k = 0; k < 6; k++) begin
      apply(0, 0, 1, 0, 0, 0, 0);
      chk($sformatf("wdog_c%0d", k), {31'd0, stall_timeout}, (k >= 5) ? 32'd1 : 32'd0);
    end
    apply(0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("wdog_sticky", {31'd0, stall_timeout}, 32'd1);
    async_reset();
    #1 chk("wdog_cleared", {31'd0, stall_timeout}, 32'd0);

    // Randomized traffic against the model, with occasional async resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0)
        async_reset();
      else
        apply($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage core. It merges per-stage stall requests into the 6-bit `stall` bus that every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb) consumes. It sequences exception/ERET flushes and supplies the redirect PC. A consecutive-stall watchdog flags a hung pipeline.

## Interface
Parameters:
- `EXC_VECTOR`, default 32'h0000_0020: PC loaded on an exception flush.
- `WDOG_LIMIT`, default 255: consecutive stalled cycles before timeout (1..65535).
- `WDOG_W`, default 16: watchdog counter width.

Ports:
- `clk` in 1: core clock, rising edge.
- `rst` in 1: reset. Asynchronous, active-high (`RstEnable`=1).
- `stallreq_if` in 1: fetch not ready.
- `stallreq_id` in 1: load-use hazard.
- `stallreq_ex` in 1: multi-cycle EX op (madd/msub/div) busy.
- `stallreq_mem` in 1: data memory not ready.
- `exc_valid` in 1: MEM-stage instruction raises an exception or ERET, from the MEM-stage exception logic.
- `exc_is_eret` in 1: qualifies `exc_valid` as ERET.
- `cp0_epc` in 32: current EPC, with forwarding already applied.
- `stall` out 6: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB. `Stop`=1.
- `flush` out 1: clear all pipeline registers this cycle.
- `new_pc` out 32: redirect target, valid when `flush`=1.
- `stall_timeout` out 1: sticky watchdog flag.

## Operation
- Stall merge is combinational, and the deepest request wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- FSM states: `IDLE`, `EXC_HOLD`.
- In `IDLE` with `exc_valid`=1:
  - `flush`=1 and `stall`=0 in the same cycle; exception overrides every stall request.
  - `new_pc` = `cp0_epc` if `exc_is_eret`, else `EXC_VECTOR`.
  - Next state is `EXC_HOLD`.
- `EXC_HOLD` lasts exactly one cycle:
  - `exc_valid` is masked, so a stale MEM-stage signal cannot double-flush. `flush`=0.
  - Stall merge operates normally.
  - Next state is `IDLE`.
- In `IDLE` without `exc_valid`: `flush`=0 and `new_pc`=0.
- Watchdog:
  - Counter increments, saturating at all-ones, on every cycle with `stall`≠0.
  - Counter clears on any cycle with `stall`=0 or `flush`=1.
  - When the count equals `WDOG_LIMIT`, `stall_timeout` sets at the next edge.
  - `stall_timeout` clears only on `rst`.
- Reset values: state `IDLE`, watchdog 0, `stall_timeout` 0. Therefore `stall`=0, `flush`=0, `new_pc`=0 while `rst`=1, regardless of inputs.

## Timing
- `stall`, `flush` and `new_pc` are combinational from the inputs and current state: zero-cycle latency, as load-use and memory-wait stalls require.
- FSM and watchdog update on the rising `clk` edge.
- Flush cycle T: pipeline registers clear at edge T+1, and pc_reg loads `new_pc` at edge T+1.
- If `exc_valid` and any stall request are both high in cycle T, the flush wins. The stall requests are reconsidered from T+1.
- Two consecutive cycles of `exc_valid` produce exactly one flush (T). The second cycle lands in `EXC_HOLD`.
- Watchdog: with `stall` held from cycle 0, the count is `WDOG_LIMIT` in cycle `WDOG_LIMIT` and `stall_timeout` is high from cycle `WDOG_LIMIT`+1.
- `rst` asserted mid-flush or mid-stall: all outputs go to reset values immediately. No pending flush survives.

## Configuration
- Macro `PIPE_CTRL_PERF_EN`.
- Defined: adds outputs `perf_stall_cycles` and `perf_flush_count`, both 32-bit, wrap-around, reset 0.
  - `perf_stall_cycles` counts cycles with `stall`≠0.
  - `perf_flush_count` counts cycles with `flush`=1.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared `defines.v` gains:
  - stall patterns `STALL_NONE`, `STALL_IF`, `STALL_ID`, `STALL_EX`, `STALL_MEM`
  - state encodings `CTRL_IDLE`, `CTRL_EXC_HOLD`
  - `EXC_VECTOR_DEFAULT`
- `StallBus`, `Stop`, `NotStop`, `RstEnable` and `ZeroWord` are reused from the same file.
- One sub-module, `stall_wdog`: the saturating counter plus the sticky timeout flag.

## Test plan
- Individual requests:
  - `stallreq_id`=1 alone → `stall`=6'b000111.
  - `stallreq_if` alone → 6'b000011.
  - `stallreq_ex` and `stallreq_id` together → 6'b001111.
  - All four requests → 6'b011111.
- Exception: `exc_valid`=1, `exc_is_eret`=0 → same cycle `flush`=1, `new_pc`=32'h20, `stall`=0. Next cycle `flush`=0.
- ERET: `exc_valid`=1, `exc_is_eret`=1, `cp0_epc`=32'h0000_1234 → `flush`=1, `new_pc`=32'h1234.
- Flush masking:
  - `exc_valid` high for 2 cycles with `stallreq_mem`=1 → exactly one `flush` pulse.
  - Second cycle `stall`=6'b011111.
- Watchdog with `WDOG_LIMIT`=4:
  - `stallreq_ex` held 6 cycles → `stall_timeout` rises after the 5th edge and stays set after the request drops.
  - `rst` clears it.
- Async reset mid-flush: assert `rst` between edges while `exc_valid`=1 → `flush`=0 and `stall`=0 immediately. With `PIPE_CTRL_PERF_EN`, both perf counters read 0.
